// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared constants and state encodings for the SoC memory responder
package soc_pkg;

  localparam int IO_PAGE_BIT = 22;
  localparam int IO_LED_WORD = 1;
  localparam int IO_SW_WORD  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Which register currently drives MEM_RDATA.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rsrc_t;

endpackage

// File: rtl/soc_bram.sv
// rtl/soc_bram.sv - WORDS x 32 byte-enabled synchronous RAM, read-before-write
module soc_bram #(
  parameter int    WORDS     = 1024,
  parameter string INIT_FILE = "",
  parameter int    ADDR_W    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [WORDS];

  // The read samples the array before this edge's byte writes land.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/soc_memory.sv
// rtl/soc_memory.sv - CPU memory-bus responder with wait states; SOC_MEMORY_IO_EN adds LED/SW IO page
module soc_memory
  import soc_pkg::*;
#(
  parameter int    WORDS       = 1024,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ADDR,
  input  logic        MEM_RSTRB,
  input  logic [31:0] MEM_WDATA,
  input  logic [3:0]  MEM_WMASK,
  output logic [31:0] MEM_RDATA,
  output logic        MEM_RBUSY,
  output logic        MEM_WBUSY,
  input  logic [2:0]  SW,
  output logic [7:0]  LED
);

  localparam int ADDR_W = $clog2(WORDS);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t            state, state_nxt;
  rsrc_t             rsrc;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q, word_idx, bram_addr;
  logic [31:0]       wdata_q, bram_wdata, bram_rdata, io_value, io_rdata_q;
  logic [3:0]        wmask_q, bram_we;
  logic              rd_q, bram_re, idle, io_sel, ram_req, io_rd, led_wr;
  logic [7:0]        led_q;
  logic              unused_bits;

  assign word_idx    = MEM_ADDR[ADDR_W+1:2];
  assign idle        = (state == ST_IDLE);
  assign ram_req     = idle && !io_sel && (MEM_RSTRB || (|MEM_WMASK));
  assign io_rd       = idle && io_sel && MEM_RSTRB;
  assign unused_bits = ^{MEM_ADDR[31:ADDR_W+2], MEM_ADDR[1:0], SW};

`ifdef SOC_MEMORY_IO_EN
  assign io_sel = MEM_ADDR[IO_PAGE_BIT];
  assign led_wr = idle && io_sel && MEM_WMASK[0] && (word_idx == ADDR_W'(IO_LED_WORD));
  always_comb begin
    io_value = '0;
    if (word_idx == ADDR_W'(IO_LED_WORD))     io_value = {24'b0, led_q};
    else if (word_idx == ADDR_W'(IO_SW_WORD)) io_value = {29'b0, SW};
  end
`else
  assign io_sel   = 1'b0;
  assign led_wr   = 1'b0;
  assign io_value = '0;
`endif

  // Zero wait states hit the RAM straight from the bus; otherwise from the latches on the last wait cycle.
  always_comb begin
    state_nxt  = state;
    bram_addr  = word_idx;
    bram_re    = 1'b0;
    bram_we    = 4'b0;
    bram_wdata = MEM_WDATA;
    if (idle) begin
      if (ram_req) begin
        if (WAIT_STATES == 0) begin
          bram_re = MEM_RSTRB;
          bram_we = MEM_WMASK;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
    end else if (cnt == CNT_LAST) begin
      state_nxt  = ST_IDLE;
      bram_addr  = addr_q;
      bram_re    = rd_q;
      bram_we    = wmask_q;
      bram_wdata = wdata_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      rsrc       <= SRC_NONE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rd_q       <= 1'b0;
      io_rdata_q <= '0;
      led_q      <= '0;
    end else begin
      state <= state_nxt;
      if (idle) begin
        cnt <= '0;
        if (ram_req) begin
          addr_q  <= word_idx;
          wdata_q <= MEM_WDATA;
          wmask_q <= MEM_WMASK;
          rd_q    <= MEM_RSTRB;
          if (WAIT_STATES == 0 && MEM_RSTRB) rsrc <= SRC_RAM;
        end
        if (io_rd) begin
          io_rdata_q <= io_value;
          rsrc       <= SRC_IO;
        end
        if (led_wr) led_q <= MEM_WDATA[7:0];
      end else begin
        cnt <= cnt + 4'd1;
        if (cnt == CNT_LAST && rd_q) rsrc <= SRC_RAM;
      end
    end
  end

  assign MEM_RDATA = (rsrc == SRC_RAM) ? bram_rdata :
                     (rsrc == SRC_IO)  ? io_rdata_q : 32'h0;
  assign MEM_RBUSY = (state == ST_WAIT) && rd_q;
  assign MEM_WBUSY = (state == ST_WAIT) && (|wmask_q);
  assign LED       = led_q;

  soc_bram #(
    .WORDS     (WORDS),
    .INIT_FILE (INIT_FILE),
    .ADDR_W    (ADDR_W)
  ) u_bram (
    .clk   (CLK),
    .re    (bram_re),
    .we    (bram_we),
    .addr  (bram_addr),
    .wdata (bram_wdata),
    .rdata (bram_rdata)
  );

endmodule

// File: tb/tb_soc_memory.sv
// tb/tb_soc_memory.sv - randomized bench for soc_memory (0 and 3 wait states) against a word-array model
module tb_soc_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0]       rstrb, rbusy, wbusy;
  logic [1:0][3:0]  wmask;
  logic [1:0][2:0]  sw;
  logic [1:0][7:0]  led;

  soc_memory #(.WORDS(1024), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESET(rst[0]), .MEM_ADDR(addr[0]), .MEM_RSTRB(rstrb[0]),
    .MEM_WDATA(wdata[0]), .MEM_WMASK(wmask[0]), .MEM_RDATA(rdata[0]),
    .MEM_RBUSY(rbusy[0]), .MEM_WBUSY(wbusy[0]), .SW(sw[0]), .LED(led[0])
  );

  soc_memory #(.WORDS(1024), .WAIT_STATES(3)) dut3 (
    .CLK(clk), .RESET(rst[1]), .MEM_ADDR(addr[1]), .MEM_RSTRB(rstrb[1]),
    .MEM_WDATA(wdata[1]), .MEM_WMASK(wmask[1]), .MEM_RDATA(rdata[1]),
    .MEM_RBUSY(rbusy[1]), .MEM_WBUSY(wbusy[1]), .SW(sw[1]), .LED(led[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [2][1024];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus request on instance k; busy, completion latency and read data judged against the model.
  task automatic access(input int k, input logic [31:0] a, input bit rd,
                        input logic [31:0] wd, input logic [3:0] wm, input bit inject);
    int          w;
    int          idx;
    logic [31:0] exp;
    w   = (k == 1) ? 3 : 0;
    idx = int'((a >> 2) % 1024);
    exp = ref_mem[k][idx];
    addr[k] = a; rstrb[k] = rd; wdata[k] = wd; wmask[k] = wm;
    @(posedge clk); #1;
    rstrb[k] = 1'b0; wmask[k] = 4'b0; addr[k] = $urandom; wdata[k] = $urandom;
    for (int c = 0; c < w; c++) begin
      check("rbusy_wait", 32'(rbusy[k]), 32'(rd));
      check("wbusy_wait", 32'(wbusy[k]), 32'(wm != 4'b0));
      if (inject && c == 0) begin
        addr[k] = $urandom & 32'hFFBF_FFFF; rstrb[k] = 1'b1; wmask[k] = 4'hF;
      end else begin
        rstrb[k] = 1'b0; wmask[k] = 4'b0;
      end
      @(posedge clk); #1;
    end
    rstrb[k] = 1'b0; wmask[k] = 4'b0;
    check("rbusy_done", 32'(rbusy[k]), 32'h0);
    check("wbusy_done", 32'(wbusy[k]), 32'h0);
    for (int b = 0; b < 4; b++)
      if (wm[b]) ref_mem[k][idx][8*b +: 8] = wd[8*b +: 8];
    if (rd) last_rd[k] = exp;
    check("rdata", rdata[k], last_rd[k]);
  endtask

`ifdef SOC_MEMORY_IO_EN
  task automatic io_cycle(input int k, input logic [31:0] a, input bit rd,
                          input logic [31:0] wd, input logic [3:0] wm);
    addr[k] = a; rstrb[k] = rd; wdata[k] = wd; wmask[k] = wm;
    @(posedge clk); #1;
    rstrb[k] = 1'b0; wmask[k] = 4'b0;
    check("io_rbusy", 32'(rbusy[k]), 32'h0);
    check("io_wbusy", 32'(wbusy[k]), 32'h0);
  endtask
`endif

  initial begin
    logic [31:0] a, old5;
    int          idx, op;
    rst = 2'b11; addr = '0; wdata = '0; rstrb = '0; wmask = '0;
    sw[0] = 3'b101; sw[1] = 3'b101;
    last_rd[0] = '0; last_rd[1] = '0;
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_rbusy", 32'(rbusy[k]), 32'h0);
      check("rst_wbusy", 32'(wbusy[k]), 32'h0);
      check("rst_led", 32'(led[k]), 32'h0);
    end
    #11 rst = 2'b00;
    @(posedge clk); #1;

    // Known contents for the words the random traffic touches.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++)
        access(k, 32'(i * 4), 1'b0, (i == 4) ? 32'hDEADBEEF : $urandom, 4'hF, 1'b0);

    access(0, 32'h10, 1'b1, 32'h0, 4'h0, 1'b0);
    check("t1_read", rdata[0], 32'hDEADBEEF);
    access(0, 32'h10, 1'b0, 32'h11223344, 4'b0101, 1'b0);
    access(0, 32'h10, 1'b1, 32'h0, 4'h0, 1'b0);
    check("t2_lanes", rdata[0], 32'hDE22BE44);
    access(1, 32'h10, 1'b1, 32'h0, 4'h0, 1'b0);
    check("t3_read_w3", rdata[1], 32'hDEADBEEF);

    for (int k = 0; k < 2; k++) begin
      access(k, 32'h1000, 1'b0, 32'hA5, 4'hF, 1'b0);
      access(k, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
      check("t5_alias", rdata[k], 32'hA5);
    end

    // Write aborted by reset must not reach the RAM.
    old5 = ref_mem[1][5];
    addr[1] = 32'h14; wdata[1] = ~old5; wmask[1] = 4'hF;
    @(posedge clk); #1;
    wmask[1] = 4'b0;
    check("t4_wbusy", 32'(wbusy[1]), 32'h1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    check("t4_wbusy_rst", 32'(wbusy[1]), 32'h0);
    check("t4_rbusy_rst", 32'(rbusy[1]), 32'h0);
    check("t4_rdata_rst", rdata[1], 32'h0);
    #1 rst[1] = 1'b0;
    last_rd[1] = 32'h0;
    @(posedge clk); #1;
    access(1, 32'h14, 1'b1, 32'h0, 4'h0, 1'b0);
    check("t4_old_data", rdata[1], old5);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 200; n++) begin
        idx = $urandom_range(0, 31);
        a   = ($urandom & 32'hFFBF_F003) | 32'(idx << 2);
        op  = $urandom_range(0, 2);
        access(k, a, op != 1, $urandom,
               (op == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
               k == 1 && $urandom_range(0, 3) == 0);
      end
    end

`ifdef SOC_MEMORY_IO_EN
    for (int k = 0; k < 2; k++) begin
      io_cycle(k, 32'h0040_0004, 1'b0, 32'h5A, 4'b0001);
      check("t6_led", 32'(led[k]), 32'h5A);
      io_cycle(k, 32'h0040_0008, 1'b1, 32'h0, 4'h0);
      check("t6_sw", rdata[k], 32'h5);
      io_cycle(k, 32'h0040_0004, 1'b1, 32'h0, 4'h0);
      check("t6_led_rd", rdata[k], 32'h5A);
      io_cycle(k, 32'h0040_0008, 1'b0, 32'hFF, 4'hF);
      io_cycle(k, 32'h0040_000C, 1'b1, 32'h0, 4'h0);
      check("t6_other", rdata[k], 32'h0);
      last_rd[k] = 32'h0;
      access(k, 32'h4, 1'b1, 32'h0, 4'h0, 1'b0);
    end
`else
    for (int k = 0; k < 2; k++) begin
      access(k, 32'h0040_0004, 1'b0, 32'h5A, 4'b0001, 1'b0);
      access(k, 32'h4, 1'b1, 32'h0, 4'h0, 1'b0);
      check("noio_led", 32'(led[k]), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
